// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: valid/ready on both sides, flush with NOP insertion, saturating bubble counter.
// Define IF_ID_SKID_EN for a 2-entry skid buffer with a registered if_ready; otherwise single entry.
module if_id_pipe_reg #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32,
    parameter logic [INST_W-1:0] NOP_INST = 'h0000_0013,
    parameter int unsigned BCNT_W = 16
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] pc_addr_if,
    input  logic [INST_W-1:0] fetched_inst_if,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic              flush,
    output logic [ADDR_W-1:0] pc_addr_id,
    output logic [INST_W-1:0] fetched_inst_id,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [BCNT_W-1:0] bubble_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
`ifdef IF_ID_SKID_EN
    localparam logic [1:0] ST_SKID  = 2'd2;
`endif

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;

`ifdef IF_ID_SKID_EN
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic              if_ready_q, if_ready_d;
`endif

    assign id_valid        = (state_q != ST_EMPTY);
    assign pc_addr_id      = pc_q;
    assign fetched_inst_id = id_valid ? inst_q : NOP_INST;
    assign bubble_cnt      = bcnt_q;

    // A flush-cycle beat is always taken so fetch can drop it after redirect.
`ifdef IF_ID_SKID_EN
    assign if_ready = if_ready_q | flush;
`else
    assign if_ready = !id_valid | id_ready | flush;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
`ifdef IF_ID_SKID_EN
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
`endif
        if (flush) begin
            state_d = ST_EMPTY;
            pc_d    = '0;
            inst_d  = NOP_INST;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (if_valid) begin
                        state_d = ST_FULL;
                        pc_d    = pc_addr_if;
                        inst_d  = fetched_inst_if;
                    end
                end
                ST_FULL: begin
                    if (id_ready) begin
                        if (if_valid) begin
                            pc_d   = pc_addr_if;
                            inst_d = fetched_inst_if;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end
`ifdef IF_ID_SKID_EN
                    else if (if_valid) begin
                        state_d     = ST_SKID;
                        skid_pc_d   = pc_addr_if;
                        skid_inst_d = fetched_inst_if;
                    end
`endif
                end
`ifdef IF_ID_SKID_EN
                ST_SKID: begin
                    if (id_ready) begin
                        state_d = ST_FULL;
                        pc_d    = skid_pc_q;
                        inst_d  = skid_inst_q;
                    end
                end
`endif
                default: state_d = ST_EMPTY;
            endcase
        end
    end

`ifdef IF_ID_SKID_EN
    // Upstream ready is purely a function of the next state, never of id_ready this cycle.
    always_comb begin
        if_ready_d = (state_d != ST_SKID);
    end
`endif

    always_comb begin
        bcnt_d = bcnt_q;
        if (id_ready && !id_valid && !flush && (bcnt_q != {BCNT_W{1'b1}})) begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_EMPTY;
            pc_q    <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            bcnt_q  <= bcnt_d;
        end
    end

`ifdef IF_ID_SKID_EN
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            if_ready_q <= 1'b1;
        end else begin
            if_ready_q <= if_ready_d;
        end
    end
`endif

    // Payload storage is masked by state, so it carries no reset.
    always_ff @(posedge sys_clk) begin
        inst_q <= inst_d;
`ifdef IF_ID_SKID_EN
        skid_pc_q   <= skid_pc_d;
        skid_inst_q <= skid_inst_d;
`endif
    end

endmodule
